// File: rtl/jk_checker.sv
// Runtime checker for an external JK flip-flop: tracks a reference model, flags q mismatches.
// Optional complement (q_bar) check is compiled in with `define JK_CHECK_COMPL_EN.
module jk_checker #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_j,
  input  logic             i_k,
  input  logic             i_q,
  input  logic             i_q_bar,
  output logic             o_exp_q,
  output logic             o_err,
  output logic [1:0]       o_err_code,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_tog_cnt
);

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic             r_model;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic             r_sticky;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_tog_cnt;

  logic w_checking;
  logic w_mismatch;
  logic w_compl;
  logic w_err_any;
  logic w_model_next;

  function automatic logic jkNext(input logic cur, input logic j, input logic k);
    case ({j, k})
      2'b00:   return cur;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~cur;
    endcase
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // en=0 always wins, so a dropped enable never performs a check on that edge
  always_comb begin
    w_next = r_state;
    if (!i_en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = SYNC;
        SYNC:    w_next = CHECK;
        default: w_next = CHECK;
      endcase
    end
  end

  assign w_checking = (r_state == CHECK) && i_en;
  assign w_mismatch = w_checking && (i_q != r_model);

`ifdef JK_CHECK_COMPL_EN
  assign w_compl = w_checking && (i_q_bar == i_q);
`else
  logic w_unused_q_bar;
  assign w_unused_q_bar = i_q_bar;
  assign w_compl        = 1'b0;
`endif

  assign w_err_any = w_mismatch | w_compl;

  // On a mismatch the model restarts from the observed q so one fault gives one error
  always_comb begin
    w_model_next = r_model;
    if ((r_state == SYNC) && i_en)
      w_model_next = jkNext(i_q, i_j, i_k);
    else if (w_checking)
      w_model_next = jkNext(w_mismatch ? i_q : r_model, i_j, i_k);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_model    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_sticky   <= 1'b0;
      r_err_cnt  <= '0;
      r_tog_cnt  <= '0;
    end else begin
      r_model    <= w_model_next;
      r_err      <= w_err_any;
      r_err_code <= {w_compl, w_mismatch};
      if (i_clr) begin
        r_sticky  <= 1'b0;
        r_err_cnt <= '0;
        r_tog_cnt <= '0;
      end else begin
        if (w_err_any) begin
          r_sticky <= 1'b1;
          if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
        end
        if (w_checking && i_j && i_k && (r_tog_cnt != CNT_MAX))
          r_tog_cnt <= r_tog_cnt + 1'b1;
      end
    end
  end

  assign o_exp_q      = r_model;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_err_sticky = r_sticky;
  assign o_err_cnt    = r_err_cnt;
  assign o_tog_cnt    = r_tog_cnt;

endmodule

// File: tb/tb_jk_checker.sv
// Table-driven scoreboard bench for jk_checker (CNT_W=2 so saturation is reachable quickly).
module tb_jk_checker;

  localparam int CNT_W = 2;

`ifdef JK_CHECK_COMPL_EN
  localparam logic [1:0] BOTH_CODE = 2'b11;
`else
  localparam logic [1:0] BOTH_CODE = 2'b01;
`endif

  typedef struct {
    logic       en;
    logic       clr;
    logic       j;
    logic       k;
    logic       q;
    logic       qb;
    logic [8:0] exp;
  } vec_t;

  logic             i_clk = 1'b0;
  logic             i_rst, i_en, i_clr, i_j, i_k, i_q, i_q_bar;
  logic             o_exp_q, o_err, o_err_sticky;
  logic [1:0]       o_err_code;
  logic [CNT_W-1:0] o_err_cnt, o_tog_cnt;

  int compared   = 0;
  int mismatched = 0;
  logic [8:0] scoreboard[$];
  vec_t mainVecs[$];
  vec_t postRstVecs[$];

  jk_checker #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_clr(i_clr),
    .i_j(i_j), .i_k(i_k), .i_q(i_q), .i_q_bar(i_q_bar),
    .o_exp_q(o_exp_q), .o_err(o_err), .o_err_code(o_err_code),
    .o_err_sticky(o_err_sticky), .o_err_cnt(o_err_cnt), .o_tog_cnt(o_tog_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Expected fields packed as {err, code, sticky, err_cnt, tog_cnt, exp_q}
  function automatic vec_t mk(input logic en, input logic clr, input logic j, input logic k,
                              input logic q, input logic qb, input logic err, input logic [1:0] code,
                              input logic sticky, input logic [1:0] ec, input logic [1:0] tc,
                              input logic eq);
    vec_t v;
    v.en = en; v.clr = clr; v.j = j; v.k = k; v.q = q; v.qb = qb;
    v.exp = {err, code, sticky, ec, tc, eq};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] expected);
    logic [8:0] actual;
    actual = {o_err, o_err_code, o_err_sticky, o_err_cnt, o_tog_cnt, o_exp_q};
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got {err,code,sticky,errcnt,togcnt,expq}=%b, expected %b",
               name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string name, input vec_t v);
    i_en = v.en; i_clr = v.clr; i_j = v.j; i_k = v.k; i_q = v.q; i_q_bar = v.qb;
    scoreboard.push_back(v.exp);
    @(posedge i_clk);
    #1;
    checkOutput(name, scoreboard.pop_front());
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 5; i++)
      mainVecs.push_back(mk(0,0,0,0,0,1, 0,2'b00,0,2'd0,2'd0,0));
    // Correct flip-flop: jk=01,10,11,11,00 once checking
    mainVecs.push_back(mk(1,0,0,0,0,1, 0,2'b00,0,2'd0,2'd0,0));
    mainVecs.push_back(mk(1,0,0,1,0,1, 0,2'b00,0,2'd0,2'd0,0));
    mainVecs.push_back(mk(1,0,1,0,0,1, 0,2'b00,0,2'd0,2'd0,1));
    mainVecs.push_back(mk(1,0,1,1,1,0, 0,2'b00,0,2'd0,2'd1,0));
    mainVecs.push_back(mk(1,0,1,1,0,1, 0,2'b00,0,2'd0,2'd2,1));
    mainVecs.push_back(mk(1,0,0,0,1,0, 0,2'b00,0,2'd0,2'd2,1));
    // Single wrong q, then resync
    mainVecs.push_back(mk(1,0,0,0,0,1, 1,2'b01,1,2'd1,2'd2,0));
    mainVecs.push_back(mk(1,0,0,0,0,1, 0,2'b00,1,2'd1,2'd2,0));
    // Wrong q together with q_bar==q
    mainVecs.push_back(mk(1,0,0,0,1,1, 1,BOTH_CODE,1,2'd2,2'd2,1));
    mainVecs.push_back(mk(1,0,0,0,1,0, 0,2'b00,1,2'd2,2'd2,1));
    // Five consecutive errors, err_cnt saturates at 3
    mainVecs.push_back(mk(1,0,0,0,0,1, 1,2'b01,1,2'd3,2'd2,0));
    mainVecs.push_back(mk(1,0,0,0,1,0, 1,2'b01,1,2'd3,2'd2,1));
    mainVecs.push_back(mk(1,0,0,0,0,1, 1,2'b01,1,2'd3,2'd2,0));
    mainVecs.push_back(mk(1,0,0,0,1,0, 1,2'b01,1,2'd3,2'd2,1));
    mainVecs.push_back(mk(1,0,0,0,0,1, 1,2'b01,1,2'd3,2'd2,0));
    // Sixth error with clr in the same cycle
    mainVecs.push_back(mk(1,1,1,1,1,0, 1,2'b01,0,2'd0,2'd0,0));
    // Toggle count saturation
    mainVecs.push_back(mk(1,0,1,1,0,1, 0,2'b00,0,2'd0,2'd1,1));
    mainVecs.push_back(mk(1,0,1,1,1,0, 0,2'b00,0,2'd0,2'd2,0));
    mainVecs.push_back(mk(1,0,1,1,0,1, 0,2'b00,0,2'd0,2'd3,1));
    mainVecs.push_back(mk(1,0,1,1,1,0, 0,2'b00,0,2'd0,2'd3,0));
    // Drop en mid-stream with a wrong q, then re-enable through SYNC
    mainVecs.push_back(mk(0,0,1,1,1,0, 0,2'b00,0,2'd0,2'd3,0));
    mainVecs.push_back(mk(0,0,0,0,0,1, 0,2'b00,0,2'd0,2'd3,0));
    mainVecs.push_back(mk(1,0,0,0,0,1, 0,2'b00,0,2'd0,2'd3,0));
    mainVecs.push_back(mk(1,0,1,0,0,1, 0,2'b00,0,2'd0,2'd3,1));
    mainVecs.push_back(mk(1,0,0,0,1,0, 0,2'b00,0,2'd0,2'd3,1));
    mainVecs.push_back(mk(1,0,0,0,0,1, 1,2'b01,1,2'd1,2'd3,0));
    // After reset in CHECK: arbitrary q during IDLE->SYNC and SYNC must not error
    postRstVecs.push_back(mk(1,0,1,1,1,1, 0,2'b00,0,2'd0,2'd0,0));
    postRstVecs.push_back(mk(1,0,0,1,1,1, 0,2'b00,0,2'd0,2'd0,0));
    postRstVecs.push_back(mk(1,0,0,0,0,1, 0,2'b00,0,2'd0,2'd0,0));
    postRstVecs.push_back(mk(1,0,1,0,0,1, 0,2'b00,0,2'd0,2'd0,1));

    i_rst = 1'b1; i_en = 1'b0; i_clr = 1'b0; i_j = 1'b0; i_k = 1'b0; i_q = 1'b0; i_q_bar = 1'b1;
    @(posedge i_clk);
    #1;
    checkOutput("reset", 9'd0);
    i_rst = 1'b0;

    foreach (mainVecs[i]) applyStimulus($sformatf("main%0d", i), mainVecs[i]);

    // Asynchronous reset while in CHECK with an error pulse showing
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("rstAsync", 9'd0);
    #2;
    i_rst = 1'b0;

    foreach (postRstVecs[i]) applyStimulus($sformatf("postRst%0d", i), postRstVecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/jk_checker.md
JK_CHECKER -- requirements
Module: jk_checker

Interface
REQ-001 Parameter CNT_W, default 8, width of err_cnt and tog_cnt.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  checking enable; 0 idles the checker.
REQ-005 clr  input  1  synchronous clear of counters and sticky flag.
REQ-006 j  input  1  J input as applied to the observed flip-flop.
REQ-007 k  input  1  K input as applied to the observed flip-flop.
REQ-008 q  input  1  observed flip-flop output.
REQ-009 q_bar  input  1  observed complementary output.
REQ-010 exp_q  output  1  model's expected q for the current cycle.
REQ-011 err  output  1  one-cycle error pulse.
REQ-012 err_code  output  2  [0]=q mismatch, [1]=complement error; valid while err=1, else 0.
REQ-013 err_sticky  output  1  set on any error; held until clr or rst.
REQ-014 err_cnt  output  CNT_W  saturating error count.
REQ-015 tog_cnt  output  CNT_W  saturating count of checked cycles with j=1,k=1.

Function
REQ-016 The FSM SHALL have three states: IDLE, SYNC, CHECK.
REQ-017 IDLE -> SYNC when en=1; SYNC -> CHECK unconditionally; SYNC or CHECK -> IDLE when en=0 (en=0 takes priority).
REQ-018 In SYNC, no check; model SHALL load f(q,j,k), with f = hold(00), reset-to-0(01), set-to-1(10), toggle(11).
REQ-019 In CHECK, each rising edge SHALL compare sampled q with model; mismatch sets err_code[0].
REQ-020 In CHECK, model SHALL update to f(model,j,k) when q matched, and to f(q,j,k) on mismatch (resync; no cascading errors).
REQ-021 exp_q SHALL equal model; err and err_code SHALL be registered, asserted the cycle after the offending edge (latency 1).
REQ-022 Simultaneous mismatch and complement error SHALL produce one err pulse, err_code=2'b11, and increment err_cnt by exactly 1.
REQ-023 err_cnt and tog_cnt SHALL saturate at 2^CNT_W-1, never wrap.
REQ-024 In CHECK, j=1,k=1 SHALL increment tog_cnt, regardless of error.
REQ-025 clr=1 SHALL zero err_cnt, tog_cnt, err_sticky next edge; clr wins over a same-cycle increment or set; err pulse still asserted.
REQ-026 In IDLE, err=0, counters and err_sticky hold, model holds.
REQ-027 en dropped mid-CHECK SHALL return to IDLE without checking that edge; re-enable SHALL pass through SYNC again.

Reset
REQ-028 rst=1 SHALL immediately force: state IDLE, model/exp_q 0, err 0, err_code 0, err_sticky 0, err_cnt 0, tog_cnt 0.
REQ-029 Reset asserted mid-CHECK SHALL abandon the check; first edge after release SHALL see state IDLE.

Configuration
REQ-030 Macro JK_CHECK_COMPL_EN SHALL gate the complement check.
REQ-031 Defined: in CHECK, q_bar != ~q SHALL set err_code[1] and count as an error.
REQ-032 Undefined: q_bar SHALL be ignored, err_code[1] SHALL be constant 0, and no complement logic SHALL be synthesized.

Verification
REQ-033 rst=1 then release, en=0 -> all outputs 0, state IDLE for 5 cycles.
REQ-034 en=1, correct DUT, sequence jk=01,10,11,11,00 -> err never asserts, tog_cnt=2, exp_q tracks q.
REQ-035 In CHECK, force q wrong for one cycle (model expects 1, q=0) -> err=1, err_code=01 one cycle, err_cnt=1, err_sticky=1; next cycle err=0 (resync).
REQ-036 With JK_CHECK_COMPL_EN, q=1, q_bar=1 and q wrong the same edge -> single err pulse, err_code=11, err_cnt +1; without macro -> err_code=01.
REQ-037 CNT_W=2, inject 5 errors -> err_cnt stops at 3; clr=1 coincident with a 6th error -> err=1, err_cnt=0, err_sticky=0.
REQ-038 Drop en mid-stream, then rst pulse while in CHECK -> IDLE immediately; on re-enable, first edge is SYNC (no error despite arbitrary q).
